pc_fetch_unit: RTL

- Program-counter register and next-PC sequencer for the single-cycle CPU fetch path.
- Holds the current instruction address and drives the word-addressed instruction-ROM address conversion directly downstream.
- Selects the next PC each cycle from one of four sources: sequential +4, branch target, jump target, or hold (stall/halt).
- Runs a small boot/run/halt state machine so fetch_valid marks the cycles in which the fetched instruction is meaningful.

---
 rtl/pc_fetch_if.sv | 80 ++++++++
 rtl/pc_fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_if
//
// Purpose: groups the fetch-control inputs and the PC/status outputs of
// pc_fetch_unit into one bundle, so the control path that drives the fetch
// unit and the consumer of its PC can be wired with a single connection.
//
// Signals (directions as seen by the fetch unit, i.e. the slave modport):
//   stall          in   hold PC for this cycle
//   branch_taken   in   conditional branch resolved taken this cycle
//   branch_target  in   [31:0] branch destination byte address
//   jump           in   unconditional jump this cycle
//   jump_target    in   [31:0] jump destination byte address
//   halt_req       in   request to stop fetching
//   resume         in   leave HALT
//   pc             out  [31:0] current instruction byte address (registered)
//   pc_plus4       out  [31:0] pc + 4, modulo 2^32
//   fetch_valid    out  instruction at pc is to be executed this cycle
//   halted         out  high while in HALT
//   trap           out  one-cycle pulse after a misaligned redirect
//                       (only when PC_ALIGN_TRAP_EN is defined)
//
// Handshake: there is no valid/ready pair here. Control inputs are sampled on
// every rising clock edge; pc is meaningful every cycle and fetch_valid
// qualifies it as an instruction that must actually be executed.
//
// Optional feature macro: PC_ALIGN_TRAP_EN (adds the trap signal).
// ---------------------------------------------------------------------------
interface pc_fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
`ifdef PC_ALIGN_TRAP_EN
  logic        trap;
`endif

  // Control side: drives the sequencing requests, observes the PC.
  modport master (
    output stall,
    output branch_taken,
    output branch_target,
    output jump,
    output jump_target,
    output halt_req,
    output resume,
    input  pc,
    input  pc_plus4,
    input  fetch_valid,
`ifdef PC_ALIGN_TRAP_EN
    input  trap,
`endif
    input  halted
  );

  // Fetch unit side.
  modport slave (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  jump,
    input  jump_target,
    input  halt_req,
    input  resume,
    output pc,
    output pc_plus4,
    output fetch_valid,
`ifdef PC_ALIGN_TRAP_EN
    output trap,
`endif
    output halted
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Purpose: program-counter register and next-PC sequencer for the
// single-cycle CPU fetch path. Each cycle the next PC is chosen from
// sequential +4, jump target, branch target or hold. A three-state
// BOOT/RUN/HALT machine decides when the fetched instruction is meaningful
// (fetch_valid) and when the core is parked (halted).
//
// Ports:
//   clk      in   system clock, all state updates on the rising edge
//   reset    in   asynchronous, active-high reset
//   bus      pc_fetch_if.slave  control inputs and PC/status outputs
//   state_o  out  [1:0] current FSM state, for debug/observation
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset (must be word aligned)
//   TRAP_VECTOR   PC loaded on a misaligned redirect (optional feature only)
//
// Optional feature macro: PC_ALIGN_TRAP_EN
//   defined   : a redirect to a target with [1:0] != 0 loads TRAP_VECTOR and
//               pulses bus.trap for one cycle.
//   undefined : target[1:0] are silently cleared; no trap signal exists.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0040
) (
  input  logic       clk,
  input  logic       reset,
  pc_fetch_if.slave  bus,
  output logic [1:0] state_o
);

  // FSM encoding.
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;

  // Redirect selection: jump beats branch; the result is only used when
  // redirect_req is set.
  logic        redirect_req;
  logic [31:0] redirect_raw;
  logic [31:0] redirect_pc;
  logic        redirect_trap;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_req = bus.jump | bus.branch_taken;
  assign redirect_raw = bus.jump ? bus.jump_target : bus.branch_target;

`ifdef PC_ALIGN_TRAP_EN
  logic trap_q, trap_d;

  // A misaligned winning target is replaced by the trap vector instead of
  // being fetched.
  always_comb begin
    redirect_trap = (redirect_raw[1:0] != 2'b00);
    redirect_pc   = redirect_trap ? TRAP_VECTOR : redirect_raw;
  end
`else
  // Without the trap feature the low address bits are simply dropped.
  always_comb begin
    redirect_trap = 1'b0;
    redirect_pc   = redirect_raw & 32'hFFFF_FFFC;
  end

  // TRAP_VECTOR has no role in this build.
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

  // Next-state / next-PC logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_ALIGN_TRAP_EN
    trap_d  = 1'b0;
`endif
    case (state_q)
      ST_BOOT: begin
        // One settling cycle after reset; inputs are ignored.
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.halt_req) begin
          // Halt wins over any redirect in the same cycle; PC is frozen.
          state_d = ST_HALT;
        end else if (redirect_req) begin
          // A redirect overrides stall and flushes the stalled fetch.
          pc_d = redirect_pc;
`ifdef PC_ALIGN_TRAP_EN
          trap_d = redirect_trap;
`endif
        end else if (!bus.stall) begin
          pc_d = pc_plus4;
        end
      end
      ST_HALT: begin
        // halt_req held alongside resume keeps the unit parked.
        if (bus.resume && !bus.halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_ALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end

  assign bus.trap = trap_q;
`else
  // redirect_trap is constant zero in this build.
  logic unused_redirect_trap;
  assign unused_redirect_trap = redirect_trap;
`endif

  // Outputs. fetch_valid follows stall combinationally in RUN so a stalled
  // cycle never issues the instruction at the held pc.
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fetch_valid = (state_q == ST_RUN) && !bus.stall;
  assign bus.halted      = (state_q == ST_HALT);
  assign state_o         = state_q;

endmodule
